// File: rtl/motor_pkg.sv
// Shared types and constants for the motor set-point sequencer.
package motor_pkg;

  localparam int unsigned MOTOR_GRAD_W = 16;

  typedef enum logic [2:0] {
    MSEQ_IDLE,
    MSEQ_ISSUE,
    MSEQ_RAMP,
    MSEQ_SETTLE,
    MSEQ_DONE
  } mseq_state_e;

endpackage

// File: rtl/motor_req_prio_arb.sv
// Fixed-priority one-hot grant: the lowest asserted request index wins.
module motor_req_prio_arb #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (grant == '0)) grant[i] = 1'b1;
    end
  end

endmodule

// File: rtl/motor_ascent_sequencer.sv
// Arbitrates set-point requesters onto the shared slow-ascent ramp engine.
// Optional ramp watchdog: define MOTOR_SEQ_TIMEOUT_EN.
module motor_ascent_sequencer
  import motor_pkg::*;
#(
  parameter real         TCQ         = 0.1,
  parameter int unsigned MOTOR_VOL   = 16,
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ*MOTOR_VOL-1:0]      req_data_i,
  input  logic [NUM_REQ*MOTOR_GRAD_W-1:0]   req_gradient_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic [MOTOR_GRAD_W-1:0]           ascent_gradient_o,
  output logic                              motor_data_in_en_o,
  output logic [MOTOR_VOL-1:0]              motor_data_in_o,
  input  logic                              motor_slow_ascent_en_i,
  input  logic [MOTOR_VOL-1:0]              motor_slow_ascent_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [$clog2(NUM_REQ)-1:0]        done_id_o,
  output logic                              timeout_o
);

  localparam int unsigned ID_W        = $clog2(NUM_REQ);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 65535 || TCQ < 0.0 || TIMEOUT_CYC == 32'd0) begin : g_bad_cfg
    $error("motor_ascent_sequencer: invalid parameter set");
  end

  mseq_state_e             state_q, state_nx;
  logic [MOTOR_VOL-1:0]    target_q, sel_data;
  logic [MOTOR_GRAD_W-1:0] grad_q, sel_grad;
  logic [ID_W-1:0]         owner_q, sel_idx;
  logic [15:0]             settle_cnt_q, settle_cnt_nx;
  logic [NUM_REQ-1:0]      grant;
  logic                    eng_match, eng_miss, preempt, ramping, wd_hit, timeout_pulse;

  motor_req_prio_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid_i),
    .grant (grant)
  );

  assign eng_match = motor_slow_ascent_en_i && (motor_slow_ascent_i == target_q);
  assign eng_miss  = motor_slow_ascent_en_i && (motor_slow_ascent_i != target_q);
  assign preempt   = req_valid_i[0] && (owner_q != '0);
  assign ramping   = (state_q == MSEQ_RAMP) || (state_q == MSEQ_SETTLE);

`ifdef MOTOR_SEQ_TIMEOUT_EN
  logic [31:0] wdog_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                 wdog_q <= '0;
    else if (state_q == MSEQ_ISSUE) wdog_q <= '0;
    else if (ramping)             wdog_q <= wdog_q + 32'd1;
  end

  // wdog_q lags the load strobe by one cycle, so TIMEOUT_CYC-1 lands the pulse exactly TIMEOUT_CYC after it
  assign wd_hit = ramping && (wdog_q == TIMEOUT_CYC - 32'd1);
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_nx      = state_q;
    settle_cnt_nx = settle_cnt_q;
    req_ready_o   = '0;
    timeout_pulse = 1'b0;
    case (state_q)
      MSEQ_IDLE: begin
        if (rst_n_i) req_ready_o = grant;
        if (rst_n_i && (|req_valid_i)) state_nx = MSEQ_ISSUE;
      end
      MSEQ_ISSUE: state_nx = MSEQ_RAMP;
      MSEQ_RAMP: begin
        if (preempt) begin
          req_ready_o[0] = 1'b1;
          state_nx       = MSEQ_ISSUE;
        end else if (wd_hit) begin
          timeout_pulse = 1'b1;
          state_nx      = MSEQ_IDLE;
        end else if (eng_match) begin
          settle_cnt_nx = 16'd1;
          state_nx      = (SETTLE_CYC == 1) ? MSEQ_DONE : MSEQ_SETTLE;
        end
      end
      MSEQ_SETTLE: begin
        if (preempt) begin
          req_ready_o[0] = 1'b1;
          state_nx       = MSEQ_ISSUE;
        end else if (wd_hit) begin
          timeout_pulse = 1'b1;
          state_nx      = MSEQ_IDLE;
        end else if (eng_match) begin
          if (settle_cnt_q == SETTLE_LAST) state_nx = MSEQ_DONE;
          else settle_cnt_nx = settle_cnt_q + 16'd1;
        end else if (eng_miss) begin
          state_nx = MSEQ_RAMP;
        end
      end
      MSEQ_DONE: state_nx = MSEQ_IDLE;
      default:   state_nx = MSEQ_IDLE;
    endcase
  end

  always_comb begin
    sel_data = '0;
    sel_grad = '0;
    sel_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready_o[i]) begin
        sel_data = req_data_i[i*MOTOR_VOL +: MOTOR_VOL];
        sel_grad = req_gradient_i[i*MOTOR_GRAD_W +: MOTOR_GRAD_W];
        sel_idx  = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= MSEQ_IDLE;
      settle_cnt_q <= '0;
      target_q     <= '0;
      grad_q       <= '0;
      owner_q      <= '0;
    end else begin
      state_q      <= state_nx;
      settle_cnt_q <= settle_cnt_nx;
      if (|req_ready_o) begin
        target_q <= sel_data;
        grad_q   <= sel_grad;
        owner_q  <= sel_idx;
      end
    end
  end

  assign ascent_gradient_o  = grad_q;
  assign motor_data_in_o    = target_q;
  assign motor_data_in_en_o = (state_q == MSEQ_ISSUE);
  assign busy_o             = (state_q == MSEQ_ISSUE) || ramping;
  assign done_o             = (state_q == MSEQ_DONE) || timeout_pulse;
  assign done_id_o          = done_o ? owner_q : '0;
  assign timeout_o          = timeout_pulse;

endmodule
